ws2812_rx_decoder: RTL and testbench
====================================

Name: ws2812_rx_decoder

Overview:
- Single-wire WS2812 NRZ decoder: the receive end of the LED-strip link that ws2812_ctrl drives.
- Measures the high time of each pulse to recover bits, and assembles them MSB-first into 24-bit GRB pixels.
- Detects the latch/reset gap and reports frame length.
- Used for loopback self-check of the LED driver and for cascading a second strip controller.

Parameters:
- T1_MIN, 30: high time in cycles at or above which a bit decodes as '1'; below it decodes as '0'.
- HIGH_MIN, 5: high pulses shorter than this are glitches; they are ignored and no bit is recorded.
- HIGH_MAX, 60: high pulses longer than this are errors.
- RESET_CYC, 2500: continuous low for this many cycles ends the frame (50 us at 50 MHz).
- PIXEL_MAX, 64: maximum pixels reported per frame.

Ports:
- sys_clk, input, 1: system clock, 50 MHz.
- sys_rst, input, 1: asynchronous, active-high reset.
- din, input, 1: WS2812 serial data in.
- pix_valid, output, 1: one-cycle strobe; a pixel is complete.
- pix_data, output, 24: pixel word, GRB order, bit 23 received first; held until the next strobe.
- pix_index, output, 7: index of pix_data within the frame, starting at 0.
- frame_done, output, 1: one-cycle strobe when the latch gap is detected.
- frame_len, output, 7: number of pixels emitted in the frame just ended; updated with frame_done and saturates at PIXEL_MAX.
- err_pulse, output, 1: one-cycle strobe on any protocol error.

Behaviour:
- Reset: all outputs 0; internal counters 0; bit/pixel buffer 0; FSM enters WAIT_GAP.
- Sampling:
  - s is din registered through one flop; in the optional build, see Optional Feature.
  - All timing counts are in cycles of s.
  - A rising or falling edge is detected in the cycle s changes.
- FSM:
  - WAIT_GAP:
    - Count low cycles; a high on s clears the count.
    - When the count reaches RESET_CYC, go to IDLE.
    - No bits are decoded in this state, so a stream joined mid-frame is discarded.
  - IDLE:
    - Bit count = 0, pixel count = 0.
    - A rising edge goes to HIGH with the high counter loaded to 1.
  - HIGH:
    - Increment the high counter while s = 1.
    - If the counter would exceed HIGH_MAX: pulse err_pulse, go to WAIT_GAP, and discard the partial pixel.
    - On a falling edge:
      - counter < HIGH_MIN: no bit is recorded.
      - counter >= T1_MIN: shift in '1'.
      - otherwise: shift in '0'.
      - Then go to LOW with the low counter cleared.
  - LOW:
    - Increment the low counter while s = 0.
    - A rising edge goes to HIGH with the counter loaded to 1.
    - When the low counter reaches RESET_CYC, the frame ends; go to IDLE.
- Pixel emit:
  - pix_valid is asserted in the cycle after the falling edge that completes bit 24.
  - pix_index = pixel count. The pixel count then increments and the bit count returns to 0.
  - Pixels with index >= PIXEL_MAX are not emitted. err_pulse fires once, on the first dropped pixel of the frame.
- Frame end:
  - frame_done pulses and frame_len is loaded with min(pixel count, PIXEL_MAX).
  - If the bit count is nonzero, the partial pixel is discarded and err_pulse fires in the same cycle.
  - A gap with zero bits received (idle line) does not pulse frame_done.
- Simultaneous events: a glitch pulse never resets the low counter for gap timing; the gap count restarts only on a valid (>= HIGH_MIN) high.
- Reset mid-frame: reset takes effect immediately and asynchronously; decoding resumes only after a full RESET_CYC gap.
- Width rules:
  - High counter: clog2(HIGH_MAX+2) bits.
  - Low counter: clog2(RESET_CYC+1) bits; saturates and does not wrap.

Optional Feature:
- Macro: WS_RX_SYNC_EN.
- Defined: din passes through a 2-flop synchronizer before the s register. Total latency from din to s is 3 cycles, and every output strobe is delayed by 2 more cycles. Use this when din comes from an off-chip pin.
- Undefined: single register. This is for on-chip loopback from ws2812_ctrl, where din is already synchronous.

Test Plan:
- Reset, then 2500-cycle low, then 24 bits of 0xFF0000 (1 = 40 high/20 low, 0 = 15 high/45 low), then a 2600-cycle low:
  - pix_valid once with pix_data = 0xFF0000 and pix_index = 0.
  - frame_done with frame_len = 1.
  - No err_pulse.
- Three pixels 0x123456, 0xABCDEF, 0x000001, then a gap: pix_index 0, 1, 2 with matching data, then frame_len = 3.
- A 3-cycle glitch high inserted between bits 10 and 11 of 0x5A5A5A: the pixel still decodes as 0x5A5A5A, with no err_pulse.
- A 70-cycle high as bit 5: err_pulse; nothing further is decoded until a 2500-cycle low, after which 0x00FF00 decodes correctly.
- 65 pixels, then a gap: 64 pix_valid strobes, one err_pulse on pixel 65, and frame_len = 64.
- 12 bits, then a gap: no pix_valid, err_pulse and frame_done in the same cycle, and frame_len = 0.
- With WS_RX_SYNC_EN defined: the first scenario's pix_valid arrives exactly 2 cycles later.

Source files
------------

// File: rtl/ws2812_rx_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ws2812_rx_decoder
// Purpose  : WS2812 single-wire NRZ receiver. Times each high pulse to
//            recover bits, packs them MSB-first into 24-bit GRB pixels,
//            detects the latch gap and reports the frame length.
// Ports    : sys_clk     - system clock
//            sys_rst     - asynchronous active-high reset
//            din         - serial data in
//            pix_valid   - 1-cycle strobe, pixel complete
//            pix_data    - GRB word, bit 23 received first, held to next strobe
//            pix_index   - index of pix_data within the frame
//            frame_done  - 1-cycle strobe on latch gap
//            frame_len   - pixels emitted in the frame just ended (saturating)
//            err_pulse   - 1-cycle strobe on any protocol error
// Options  : WS_RX_SYNC_EN - add a 2-flop synchronizer in front of the
//            sample register (off-chip din); every strobe moves 2 cycles later.
// Revision : 1.0 - initial release
// ============================================================================
module ws2812_rx_decoder #(
  parameter int T1_MIN    = 30,
  parameter int HIGH_MIN  = 5,
  parameter int HIGH_MAX  = 60,
  parameter int RESET_CYC = 2500,
  parameter int PIXEL_MAX = 64
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        din,
  output logic        pix_valid,
  output logic [23:0] pix_data,
  output logic [6:0]  pix_index,
  output logic        frame_done,
  output logic [6:0]  frame_len,
  output logic        err_pulse
);

  localparam int c_hcnt_w = $clog2(HIGH_MAX + 2);
  localparam int c_lcnt_w = $clog2(RESET_CYC + 1);

  localparam logic [c_hcnt_w-1:0] c_t1_min    = c_hcnt_w'(T1_MIN);
  localparam logic [c_hcnt_w-1:0] c_high_min  = c_hcnt_w'(HIGH_MIN);
  localparam logic [c_hcnt_w-1:0] c_high_max  = c_hcnt_w'(HIGH_MAX);
  localparam logic [c_hcnt_w-1:0] c_hcnt_one  = c_hcnt_w'(1);
  localparam logic [c_lcnt_w-1:0] c_reset_cyc = c_lcnt_w'(RESET_CYC);
  localparam logic [c_lcnt_w-1:0] c_lcnt_one  = c_lcnt_w'(1);
  localparam logic [6:0]          c_pix_max   = 7'(PIXEL_MAX);

  typedef enum logic [1:0] {
    ST_WAIT_GAP = 2'd0,
    ST_IDLE     = 2'd1,
    ST_HIGH     = 2'd2,
    ST_LOW      = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Input sampling
  // --------------------------------------------------------------------------
  logic w_din_in;

`ifdef WS_RX_SYNC_EN
  logic r_sync1, r_sync2;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
    end
  end

  assign w_din_in = r_sync2;
`else
  assign w_din_in = din;
`endif

  logic r_s, r_s_prev;
  logic w_rise, w_fall;

  assign w_rise = r_s & ~r_s_prev;
  assign w_fall = ~r_s & r_s_prev;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_t              r_state, w_state_next;
  logic [c_hcnt_w-1:0] r_hcnt,  w_hcnt_next;
  logic [c_lcnt_w-1:0] r_lcnt,  w_lcnt_next, w_lcnt_inc;
  logic [4:0]          r_bcnt,  w_bcnt_next;
  logic [6:0]          r_pcnt,  w_pcnt_next;
  // Only the first 23 bits are buffered; bit 24 goes straight to pix_data.
  logic [22:0]         r_shift, w_shift_next;
  logic                r_got,   w_got_next;   // any bit recorded this frame
  logic                r_drop,  w_drop_next;  // overflow error already raised
  logic                w_bit;

  logic                w_pix_valid, w_frame_done, w_err;
  logic [23:0]         w_pix_data;
  logic [6:0]          w_pix_index, w_frame_len;

  assign w_bit      = (r_hcnt >= c_t1_min);
  assign w_lcnt_inc = (r_lcnt == c_reset_cyc) ? r_lcnt : r_lcnt + c_lcnt_one;

  always_comb begin
    w_state_next = r_state;
    w_hcnt_next  = r_hcnt;
    w_lcnt_next  = r_lcnt;
    w_bcnt_next  = r_bcnt;
    w_pcnt_next  = r_pcnt;
    w_shift_next = r_shift;
    w_got_next   = r_got;
    w_drop_next  = r_drop;
    w_pix_valid  = 1'b0;
    w_pix_data   = pix_data;
    w_pix_index  = pix_index;
    w_frame_done = 1'b0;
    w_frame_len  = frame_len;
    w_err        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_lcnt_next  = '0;
        w_bcnt_next  = '0;
        w_pcnt_next  = '0;
        w_shift_next = '0;
        w_got_next   = 1'b0;
        w_drop_next  = 1'b0;
        if (w_rise) begin
          w_state_next = ST_HIGH;
          w_hcnt_next  = c_hcnt_one;
        end
      end

      ST_HIGH: begin
        if (w_fall) begin
          w_state_next = ST_LOW;
          // Glitches leave the gap counter running so they cannot
          // stretch or restart latch detection.
          if (r_hcnt >= c_high_min) begin
            w_lcnt_next = '0;
            w_got_next  = 1'b1;
            if (r_bcnt == 5'd23) begin
              w_bcnt_next  = '0;
              w_shift_next = '0;
              if (r_pcnt < c_pix_max) begin
                w_pix_valid = 1'b1;
                w_pix_data  = {r_shift, w_bit};
                w_pix_index = r_pcnt;
                w_pcnt_next = r_pcnt + 7'd1;
              end else if (!r_drop) begin
                w_err       = 1'b1;
                w_drop_next = 1'b1;
              end
            end else begin
              w_bcnt_next  = r_bcnt + 5'd1;
              w_shift_next = {r_shift[21:0], w_bit};
            end
          end
        end else if (r_hcnt == c_high_max) begin
          // Pulse too long: abandon the frame and resynchronise on a gap.
          w_err        = 1'b1;
          w_state_next = ST_WAIT_GAP;
          w_lcnt_next  = '0;
          w_bcnt_next  = '0;
          w_shift_next = '0;
        end else begin
          w_hcnt_next = r_hcnt + c_hcnt_one;
        end
      end

      ST_LOW: begin
        if (w_rise) begin
          w_state_next = ST_HIGH;
          w_hcnt_next  = c_hcnt_one;
        end else begin
          w_lcnt_next = w_lcnt_inc;
          if (w_lcnt_inc == c_reset_cyc) begin
            w_state_next = ST_IDLE;
            if (r_got) begin
              w_frame_done = 1'b1;
              w_frame_len  = r_pcnt;
              w_err        = (r_bcnt != 5'd0);
            end
          end
        end
      end

      default: begin  // ST_WAIT_GAP
        if (r_s) begin
          w_lcnt_next = '0;
        end else begin
          w_lcnt_next = w_lcnt_inc;
          if (w_lcnt_inc == c_reset_cyc) begin
            w_state_next = ST_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_s        <= 1'b0;
      r_s_prev   <= 1'b0;
      r_state    <= ST_WAIT_GAP;
      r_hcnt     <= '0;
      r_lcnt     <= '0;
      r_bcnt     <= '0;
      r_pcnt     <= '0;
      r_shift    <= '0;
      r_got      <= 1'b0;
      r_drop     <= 1'b0;
      pix_valid  <= 1'b0;
      pix_data   <= '0;
      pix_index  <= '0;
      frame_done <= 1'b0;
      frame_len  <= '0;
      err_pulse  <= 1'b0;
    end else begin
      r_s        <= w_din_in;
      r_s_prev   <= r_s;
      r_state    <= w_state_next;
      r_hcnt     <= w_hcnt_next;
      r_lcnt     <= w_lcnt_next;
      r_bcnt     <= w_bcnt_next;
      r_pcnt     <= w_pcnt_next;
      r_shift    <= w_shift_next;
      r_got      <= w_got_next;
      r_drop     <= w_drop_next;
      pix_valid  <= w_pix_valid;
      pix_data   <= w_pix_data;
      pix_index  <= w_pix_index;
      frame_done <= w_frame_done;
      frame_len  <= w_frame_len;
      err_pulse  <= w_err;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ws2812_rx_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ws2812_rx_decoder
// Purpose  : Self-checking bench for ws2812_rx_decoder. Frames are built from
//            pixel words and pulse widths; expected strobes come from a table
//            of scenario records and from a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ws2812_rx_decoder;

`ifdef WS_RX_SYNC_EN
  localparam int C_LAT = 5;
`else
  localparam int C_LAT = 3;
`endif
  localparam int C_GAP = 2510;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        din;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic [6:0]  pix_index;
  logic        frame_done;
  logic [6:0]  frame_len;
  logic        err_pulse;

  ws2812_rx_decoder dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .din        (din),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_index  (pix_index),
    .frame_done (frame_done),
    .frame_len  (frame_len),
    .err_pulse  (err_pulse)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int last_fall = 0;
  int g_mode = 0;   // 0 nominal timing, 1 compact, 2 random, 3 width corners
  int bnd_tog = 0;

  logic [23:0] pv_data[$];
  logic [6:0]  pv_idx[$];
  int          pv_cyc[$];
  logic [6:0]  fd_len[$];
  int          fd_cyc[$];
  int          er_cyc[$];
  logic [23:0] sent_q[$];

  always @(negedge sys_clk) begin
    cyc = cyc + 1;
    if (pix_valid === 1'b1) begin
      pv_data.push_back(pix_data);
      pv_idx.push_back(pix_index);
      pv_cyc.push_back(cyc);
    end
    if (frame_done === 1'b1) begin
      fd_len.push_back(frame_len);
      fd_cyc.push_back(cyc);
    end
    if (err_pulse === 1'b1) er_cyc.push_back(cyc);
  end

  typedef struct {
    string       name;
    int          npix;
    int          part;
    int          gbit;
    logic [23:0] w0, w1, w2;
    bit          nominal;
    bit          chk_lat;
    int          e_valid, e_len, e_err, e_done;
  } vec_t;

  vec_t tbl[6];

  function automatic vec_t mk(input string nm, input int np, input int pt, input int gb,
                              input logic [23:0] a, input logic [23:0] b, input logic [23:0] c,
                              input bit nom, input bit lat,
                              input int ev, input int el, input int ee, input int ed);
    vec_t v;
    v.name = nm; v.npix = np; v.part = pt; v.gbit = gb;
    v.w0 = a; v.w1 = b; v.w2 = c; v.nominal = nom; v.chk_lat = lat;
    v.e_valid = ev; v.e_len = el; v.e_err = ee; v.e_done = ed;
    return v;
  endfunction

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic clear_events();
    pv_data.delete(); pv_idx.delete(); pv_cyc.delete();
    fd_len.delete(); fd_cyc.delete(); er_cyc.delete(); sent_q.delete();
  endtask

  // Called just after a rising clock edge; din holds v for exactly n cycles.
  task automatic hold(input logic v, input int n);
    din = v;
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic pulse(input int hi, input int lo);
    hold(1'b1, hi);
    last_fall = cyc;
    hold(1'b0, lo);
  endtask

  task automatic send_bit(input logic b);
    case (g_mode)
      0: if (b) pulse(40, 20); else pulse(15, 45);
      1: if (b) pulse(30, 2);  else pulse(6, 2);
      2: if (b) pulse(int'($urandom_range(60, 30)), int'($urandom_range(20, 2)));
         else   pulse(int'($urandom_range(29, 5)),  int'($urandom_range(20, 2)));
      default: begin
        bnd_tog = 1 - bnd_tog;
        if (b) pulse((bnd_tog != 0) ? 60 : 30, 10);
        else   pulse((bnd_tog != 0) ? 29 : 5, 10);
      end
    endcase
  endtask

  task automatic glitch();
    if (g_mode == 2) pulse(int'($urandom_range(4, 1)), int'($urandom_range(20, 2)));
    else             pulse(3, 5);
  endtask

  task automatic send_word(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) send_bit(w[i]);
  endtask

  // Full pixels, then `part` random trailing bits; a glitch goes before bit gbit.
  task automatic send_frame(input int npix, input int part, input int gbit,
                            input logic [23:0] w0, input logic [23:0] w1, input logic [23:0] w2);
    int b;
    logic [23:0] w;
    b = 0;
    for (int k = 0; k < npix; k++) begin
      w = (k == 0) ? w0 : (k == 1) ? w1 : (k == 2) ? w2 : {8'(k), 16'h0000};
      sent_q.push_back(w);
      for (int i = 23; i >= 0; i--) begin
        if (b == gbit) glitch();
        send_bit(w[i]);
        b++;
      end
    end
    for (int i = 0; i < part; i++) begin
      if (b == gbit) glitch();
      send_bit(1'($urandom_range(1, 0)));
      b++;
    end
    if (b == gbit) glitch();
  endtask

  // Frame-level reference: what a frame of n whole pixels plus part stray bits yields.
  task automatic model(input int n, input int part, output int ev, output int el,
                       output int ee, output int ed);
    ev = (n > 64) ? 64 : n;
    el = ev;
    ee = ((n > 64) ? 1 : 0) + ((part > 0) ? 1 : 0);
    ed = (n > 0 || part > 0) ? 1 : 0;
  endtask

  task automatic check_events(input string nm, input int e_valid, input int e_len,
                              input int e_err, input int e_done, input bit same_cyc);
    cmp({nm, ".valid_cnt"}, pv_data.size(), e_valid);
    for (int k = 0; k < pv_data.size() && k < e_valid; k++) begin
      cmp($sformatf("%s.data[%0d]", nm, k), pv_data[k], sent_q[k]);
      cmp($sformatf("%s.index[%0d]", nm, k), pv_idx[k], k);
    end
    cmp({nm, ".done_cnt"}, fd_len.size(), e_done);
    if (fd_len.size() > 0) cmp({nm, ".frame_len"}, fd_len[0], e_len);
    cmp({nm, ".err_cnt"}, er_cyc.size(), e_err);
    if (same_cyc && er_cyc.size() > 0 && fd_cyc.size() > 0)
      cmp({nm, ".err_with_done"}, er_cyc[0], fd_cyc[0]);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat_fall;
    int n, part, gbit, ev, el, ee, ed;

    sys_rst = 1'b1;
    din     = 1'b0;

    tbl[0] = mk("single",      1,  0, -1, 24'hFF0000, 24'h0,      24'h0,      1, 1, 1,  1,  0, 1);
    tbl[1] = mk("three",       3,  0, -1, 24'h123456, 24'hABCDEF, 24'h000001, 1, 0, 3,  3,  0, 1);
    tbl[2] = mk("glitch",      1,  0, 10, 24'h5A5A5A, 24'h0,      24'h0,      0, 0, 1,  1,  0, 1);
    tbl[3] = mk("overflow",    65, 0, -1, 24'h000000, 24'h000000, 24'h000000, 0, 0, 64, 64, 1, 1);
    tbl[4] = mk("partial",     0, 12, -1, 24'h0,      24'h0,      24'h0,      0, 0, 0,  0,  1, 1);
    tbl[5] = mk("idle_glitch", 0,  0,  0, 24'h0,      24'h0,      24'h0,      0, 0, 0,  0,  0, 0);

    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    cmp("reset.pix_valid",  pix_valid,  1'b0);
    cmp("reset.pix_data",   pix_data,   24'h0);
    cmp("reset.pix_index",  pix_index,  7'h0);
    cmp("reset.frame_done", frame_done, 1'b0);
    cmp("reset.frame_len",  frame_len,  7'h0);
    cmp("reset.err_pulse",  err_pulse,  1'b0);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    hold(1'b0, C_GAP);

    // Table-driven scenarios
    for (int t = 0; t < 6; t++) begin
      clear_events();
      g_mode = tbl[t].nominal ? 0 : 1;
      send_frame(tbl[t].npix, tbl[t].part, tbl[t].gbit, tbl[t].w0, tbl[t].w1, tbl[t].w2);
      lat_fall = last_fall;
      hold(1'b0, C_GAP + 90);
      check_events(tbl[t].name, tbl[t].e_valid, tbl[t].e_len, tbl[t].e_err,
                   tbl[t].e_done, tbl[t].part > 0);
      if (tbl[t].chk_lat && pv_cyc.size() > 0)
        cmp({tbl[t].name, ".latency"}, pv_cyc[0] - lat_fall, C_LAT);
    end

    // Over-long high as bit 5: error, then ignored until a full gap
    clear_events();
    g_mode = 1;
    for (int i = 23; i >= 0; i--) begin
      if (i == 18) pulse(70, 20);
      else         send_bit(1'b1);
    end
    hold(1'b0, C_GAP);
    sent_q.push_back(24'h00FF00);
    send_word(24'h00FF00);
    hold(1'b0, C_GAP);
    check_events("long_high", 1, 1, 1, 1, 1'b0);

    // Pulse widths right at the decision thresholds
    clear_events();
    g_mode = 3;
    bnd_tog = 0;
    sent_q.push_back(24'hA5C3F0);
    send_word(24'hA5C3F0);
    hold(1'b0, C_GAP);
    check_events("width_corners", 1, 1, 0, 1, 1'b0);

    // Asynchronous reset mid-pixel, then decoding only after a full gap
    g_mode = 1;
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    #2;
    sys_rst = 1'b1;
    #1;
    cmp("async_rst.pix_data",  pix_data,  24'h0);
    cmp("async_rst.frame_len", frame_len, 7'h0);
    cmp("async_rst.pix_valid", pix_valid, 1'b0);
    din = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    clear_events();
    send_word(24'h111111);
    hold(1'b0, C_GAP);
    sent_q.push_back(24'h222222);
    send_word(24'h222222);
    hold(1'b0, C_GAP);
    check_events("rst_resume", 1, 1, 0, 1, 1'b0);

    // Randomized frames against the frame-level model
    g_mode = 2;
    for (int r = 0; r < 4; r++) begin
      clear_events();
      n    = int'($urandom_range(3, 0));
      part = ($urandom_range(2, 0) == 0) ? int'($urandom_range(23, 1)) : 0;
      gbit = ($urandom_range(1, 0) == 1) ? int'($urandom_range(n * 24 + part, 0)) : -1;
      send_frame(n, part, gbit, 24'($urandom), 24'($urandom), 24'($urandom));
      model(n, part, ev, el, ee, ed);
      hold(1'b0, C_GAP);
      check_events($sformatf("rand%0d", r), ev, el, ee, ed, part > 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
